regfile_wb_scheduler: RTL
=========================

# regfile_wb_scheduler

Write-back scheduler for the 32-entry integer register file. It shares the register file's single write port between two producers: requester 0 (ALU/execute) and requester 1 (load/long-latency unit). It arbitrates round-robin and registers the winning write onto the port. It also keeps a pending-destination scoreboard so the issue stage can stall on RAW and WAW hazards.

## Interface
- WORD_LENGTH, 32, data width of register file entries

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a write
- req0_add  in  5  requester 0 destination register
- req0_data  in  WORD_LENGTH  requester 0 write data
- req0_ready  out  1  requester 0 granted this cycle
- req1_valid / req1_add / req1_data / req1_ready  same as requester 0, for requester 1
- write_enable  out  1  register file write enable (registered)
- write_add  out  5  register file write address (registered)
- write_data  out  WORD_LENGTH  register file write data (registered)
- issue_valid  in  1  issue stage allocating destination issue_rd
- issue_rd  in  5  destination register being allocated
- issue_ready  out  1  allocation accepted (combinational)
- chk_rs1, chk_rs2  in  5  source registers to check
- rs1_busy, rs2_busy  out  1  source register has a pending write (combinational)
- pending  out  32  scoreboard vector; bit 0 is always 0

## Operation
- Transfer on requester k: reqk_valid & reqk_ready.
- Arbitration (combinational):
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester not granted last gets ready=1.
  - Neither valid: both ready=0.
  - At most one ready is high in any cycle; ready may depend on valid.
- Round-robin pointer last_grant (1 bit) updates to the granted id on every transfer. Reset value is 1, so requester 0 wins the first tie.
- Output register on a transfer:
  - write_add and write_data load the granted requester's add and data.
  - write_enable loads (add != 0). A write to x0 is consumed but never asserted to the register file.
- Output register with no transfer: write_enable=0; write_add and write_data hold their values.
- Scoreboard pending[31:1]:
  - Set: issue_valid & issue_ready & issue_rd!=0 sets pending[issue_rd].
  - Clear: write_enable=1 clears pending[write_add] at the next rising edge, the same edge on which the register file captures the data.
  - Set and clear of different registers on the same edge both take effect.
- issue_ready = !pending[issue_rd], which blocks WAW. issue_rd=0 is always ready.
  - A register being cleared this cycle is still pending, so issue_ready=0; the same register cannot be set and cleared on one edge.
- rsN_busy = pending[chk_rsN]. x0 is never busy.
- A write from a requester to a non-pending register is accepted and performed; the scoreboard is unchanged.

## Timing
- Reset (rst low, asynchronous): write_enable=0, write_add=0, write_data=0, pending=0, last_grant=1.
  - Combinational outputs follow the reset state: issue_ready=1, rs*_busy=0.
  - ready still follows valid.
  - An in-flight registered write is dropped immediately.
- Latency: a transfer at edge N puts write_enable high in cycle N→N+1. The register file writes at edge N+1, and pending clears at edge N+1.
- Throughput: one write per cycle. Under continuous contention the grant alternates 0,1,0,1…
- A requester holding valid with ready=0 must keep add/data stable; it is guaranteed a grant within 1 cycle.
- A source cleared at edge N+1 reads busy=0 and correct data from the combinational register file read in the same cycle.

## Test plan
- Reset mid-write: set pending[5] and start a write to x5, then assert rst low before edge N+1 → write_enable=0 at once, pending=0, x5 not written.
- Single requester: req0 writes x3=0xDEADBEEF at edge 1 → write_enable=1, write_add=3, write_data=0xDEADBEEF during cycle 1–2, then write_enable=0.
- Contention: both valid for 4 cycles after reset (req0 x1, req1 x2) → grant sequence 0,1,0,1; each requester sees ready high on alternate cycles; no lost writes.
- Scoreboard: issue x7 → pending[7]=1 and rs1_busy=1 for chk_rs1=7; second issue of x7 gives issue_ready=0; req1 writes x7 → busy drops on the edge the data lands.
- x0 handling: issue x0 → issue_ready=1 and pending unchanged; req0 write to x0 → req0_ready=1, write_enable stays 0.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
//
// Write-back scheduler for the 32-entry integer register file. Two producers
// share the single register file write port: requester 0 (ALU/execute) and
// requester 1 (load/long-latency unit). A round-robin arbiter picks at most
// one requester per cycle, and the winner's write is registered onto the port.
// A pending-destination scoreboard lets the issue stage stall on RAW and WAW
// hazards.
//
// Ports
//   clk, rst                        clock (rising edge), async active-low reset
//   req0_valid/add/data, req0_ready requester 0 write channel
//   req1_valid/add/data, req1_ready requester 1 write channel
//   write_enable/add/data           registered register file write port
//   issue_valid, issue_rd           destination allocation from issue stage
//   issue_ready                     allocation accepted (combinational)
//   chk_rs1, chk_rs2                source registers to check
//   rs1_busy, rs2_busy              source has a pending write (combinational)
//   pending                         scoreboard vector, bit 0 always 0

module regfile_wb_scheduler #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   req0_valid,
  input  logic [4:0]             req0_add,
  input  logic [WORD_LENGTH-1:0] req0_data,
  output logic                   req0_ready,

  input  logic                   req1_valid,
  input  logic [4:0]             req1_add,
  input  logic [WORD_LENGTH-1:0] req1_data,
  output logic                   req1_ready,

  output logic                   write_enable,
  output logic [4:0]             write_add,
  output logic [WORD_LENGTH-1:0] write_data,

  input  logic                   issue_valid,
  input  logic [4:0]             issue_rd,
  output logic                   issue_ready,

  input  logic [4:0]             chk_rs1,
  input  logic [4:0]             chk_rs2,
  output logic                   rs1_busy,
  output logic                   rs2_busy,

  output logic [31:0]            pending
);

  // Round-robin pointer: id of the requester granted most recently.
  logic                   last_grant;

  // Scoreboard storage; x0 has no entry because it can never be pending.
  logic [31:1]            pending_q;
  logic [31:1]            pending_next;

  logic                   grant_any;
  logic                   grant_id;
  logic [4:0]             grant_add;
  logic [WORD_LENGTH-1:0] grant_data;
  logic                   alloc_en;

  // Arbitration: a lone valid requester always wins; on a tie the requester
  // that did not win last time goes first.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (req0_valid && req1_valid) begin
      req0_ready = last_grant;
      req1_ready = !last_grant;
    end else begin
      req0_ready = req0_valid;
      req1_ready = req1_valid;
    end
  end

  // Mux the winning request toward the output register.
  always_comb begin
    grant_any  = req0_ready || req1_ready;
    grant_id   = req1_ready;
    grant_add  = req1_ready ? req1_add  : req0_add;
    grant_data = req1_ready ? req1_data : req0_data;
  end

  // Pointer only moves when a transfer actually happens.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (grant_any) begin
      last_grant <= grant_id;
    end
  end

  // Output register. Writes to x0 are consumed but never reach the register
  // file. Address and data hold when idle; only the enable drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_enable <= 1'b0;
      write_add    <= '0;
      write_data   <= '0;
    end else if (grant_any) begin
      write_enable <= (grant_add != 5'd0);
      write_add    <= grant_add;
      write_data   <= grant_data;
    end else begin
      write_enable <= 1'b0;
    end
  end

  assign pending = {pending_q, 1'b0};

  // An entry being cleared this cycle still reads as pending, so a new
  // allocation to the same register waits one more cycle. This keeps set and
  // clear of one register from ever landing on the same edge.
  assign issue_ready = !pending[issue_rd];
  assign alloc_en    = issue_valid && issue_ready && (issue_rd != 5'd0);

  assign rs1_busy = pending[chk_rs1];
  assign rs2_busy = pending[chk_rs2];

  // Clear follows the registered write (same edge the register file
  // captures the data); set follows an accepted allocation.
  always_comb begin
    pending_next = pending_q;
    for (int i = 1; i < 32; i++) begin
      if (write_enable && (write_add == 5'(i))) begin
        pending_next[i] = 1'b0;
      end
      if (alloc_en && (issue_rd == 5'(i))) begin
        pending_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_next;
    end
  end

endmodule
